// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the CPU data
// side (port 0) and a debug/DMA master (port 1), with bounded burst locking.
module data_memory_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic        lock0,
    input  logic        lock1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wd0,
    input  logic [31:0] wd1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] mem_a,
    output logic        mem_we,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    state_t           state;
    logic             last;
    logic [CNT_W-1:0] burst_cnt;
    logic [CNT_W-1:0] cnt_inc;

    logic keep0, keep1, arb0, arb1;
    logic sel_we, misal;

    always_comb begin
        // An owner keeps the slot until its budget runs out, but only while
        // the other port is actually waiting.
        keep0 = (state == OWN0) && req0 && ((burst_cnt < MAX_CNT) || !req1);
        keep1 = (state == OWN1) && req1 && ((burst_cnt < MAX_CNT) || !req0);
        arb0  = req0 && (!req1 || last);
        arb1  = req1 && (!req0 || !last);
        gnt0  = rst_n && (keep0 || (!keep1 && arb0));
        gnt1  = rst_n && (keep1 || (!keep0 && arb1));

        mem_a  = 32'd0;
        mem_wd = 32'd0;
        sel_we = 1'b0;
        if (gnt0) begin
            mem_a  = addr0;
            mem_wd = wd0;
            sel_we = we0;
        end else if (gnt1) begin
            mem_a  = addr1;
            mem_wd = wd1;
            sel_we = we1;
        end
        misal  = (mem_a[1:0] != 2'b00);
        mem_we = (gnt0 || gnt1) && sel_we && !misal;

        cnt_inc = (burst_cnt == MAX_CNT) ? MAX_CNT : burst_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= 1'b1;
            burst_cnt <= '0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            rdata0    <= 32'd0;
            rdata1    <= 32'd0;
            err0      <= 1'b0;
            err1      <= 1'b0;
        end else begin
            rvalid0 <= gnt0 && !we0;
            rvalid1 <= gnt1 && !we1;
            err0    <= gnt0 && misal;
            err1    <= gnt1 && misal;
            if (gnt0 && !we0)
                rdata0 <= misal ? 32'd0 : mem_rd;
            if (gnt1 && !we1)
                rdata1 <= misal ? 32'd0 : mem_rd;

            if (gnt0) begin
                last <= 1'b0;
                if (lock0) begin
                    state     <= OWN0;
                    burst_cnt <= keep0 ? cnt_inc : CNT_W'(1);
                end else begin
                    state     <= IDLE;
                    burst_cnt <= '0;
                end
            end else if (gnt1) begin
                last <= 1'b1;
                if (lock1) begin
                    state     <= OWN1;
                    burst_cnt <= keep1 ? cnt_inc : CNT_W'(1);
                end else begin
                    state     <= IDLE;
                    burst_cnt <= '0;
                end
            end else begin
                state     <= IDLE;
                burst_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Scoreboard bench for data_memory_arbiter: a behavioural memory plus a
// reference copy predicts read returns, errors and write effects.
module tb_data_memory_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1, we0, we1, lock0, lock1;
    logic [31:0] addr0, addr1, wd0, wd1;
    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic [31:0] mem_a, mem_wd, mem_rd;
    logic        mem_we;

    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];

    typedef struct {
        logic        rv0;
        logic [31:0] rd0;
        logic        e0;
        logic        rv1;
        logic [31:0] rd1;
        logic        e1;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    assign mem_rd = mem[mem_a[7:2]];

    data_memory_arbiter #(.MAX_BURST(4), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .lock0(lock0), .lock1(lock1),
        .addr0(addr0), .addr1(addr1), .wd0(wd0), .wd1(wd1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .err0(err0), .err1(err1),
        .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        req0 = 0; we0 = 0; lock0 = 0; addr0 = 0; wd0 = 0;
        req1 = 0; we1 = 0; lock1 = 0; addr1 = 0; wd1 = 0;
    endtask

    // One arbitration cycle: drive at negedge, check grant-side outputs,
    // predict the returns, then check them one cycle later.
    task automatic cyc(input logic r0, input logic w0, input logic l0,
                       input logic [31:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic l1,
                       input logic [31:0] a1, input logic [31:0] d1,
                       input logic eg0, input logic eg1);
        exp_t        e;
        exp_t        o;
        logic        mis;
        logic        ewe;
        logic [31:0] ea, ewd;
        logic        cap_we;
        logic [31:0] cap_a, cap_wd;
        @(negedge clk);
        req0 = r0; we0 = w0; lock0 = l0; addr0 = a0; wd0 = d0;
        req1 = r1; we1 = w1; lock1 = l1; addr1 = a1; wd1 = d1;
        #1;
        chk("gnt0", {31'd0, gnt0}, {31'd0, eg0});
        chk("gnt1", {31'd0, gnt1}, {31'd0, eg1});
        ea  = eg0 ? a0 : (eg1 ? a1 : 32'd0);
        ewd = eg0 ? d0 : (eg1 ? d1 : 32'd0);
        mis = (ea[1:0] != 2'b00);
        ewe = ((eg0 && w0) || (eg1 && w1)) && !mis;
        chk("mem_a", mem_a, ea);
        chk("mem_we", {31'd0, mem_we}, {31'd0, ewe});
        if (ewe)
            chk("mem_wd", mem_wd, ewd);
        e.rv0 = eg0 && !w0;
        e.e0  = eg0 && mis;
        e.rd0 = mis ? 32'd0 : ref_mem[a0[7:2]];
        e.rv1 = eg1 && !w1;
        e.e1  = eg1 && mis;
        e.rd1 = mis ? 32'd0 : ref_mem[a1[7:2]];
        exp_q.push_back(e);
        cap_we = mem_we; cap_a = mem_a; cap_wd = mem_wd;
        @(posedge clk);
        if (cap_we)
            mem[cap_a[7:2]] = cap_wd;
        if (ewe)
            ref_mem[ea[7:2]] = ewd;
        #1;
        if (exp_q.size() == 0) begin
            chk("queue_empty", 32'd1, 32'd0);
        end else begin
            o = exp_q.pop_front();
            chk("rvalid0", {31'd0, rvalid0}, {31'd0, o.rv0});
            chk("rvalid1", {31'd0, rvalid1}, {31'd0, o.rv1});
            chk("err0", {31'd0, err0}, {31'd0, o.e0});
            chk("err1", {31'd0, err1}, {31'd0, o.e1});
            if (o.rv0) chk("rdata0", rdata0, o.rd0);
            if (o.rv1) chk("rdata1", rdata1, o.rd1);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        set_idle();
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        exp_q.delete();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]     = 32'(i * 11 + 33);
            ref_mem[i] = 32'(i * 11 + 33);
        end
        set_idle();
        rst_n = 0;
        // Requests asserted while in reset must not grant or write.
        req0 = 1; we0 = 1; req1 = 1; we1 = 1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_gnt0", {31'd0, gnt0}, 32'd0);
        chk("rst_gnt1", {31'd0, gnt1}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_rvalid0", {31'd0, rvalid0}, 32'd0);
        chk("rst_rvalid1", {31'd0, rvalid1}, 32'd0);
        chk("rst_err", {30'd0, err0, err1}, 32'd0);
        chk("rst_rdata0", rdata0, 32'd0);
        chk("rst_rdata1", rdata1, 32'd0);
        @(negedge clk);
        set_idle();
        rst_n = 1;

        // Lone aligned read, misaligned read, idle cycle.
        cyc(1, 0, 0, 32'd8, 0,  0, 0, 0, 0, 0,  1, 0);
        cyc(1, 0, 0, 32'd9, 0,  0, 0, 0, 0, 0,  1, 0);
        cyc(0, 0, 0, 0, 0,      0, 0, 0, 0, 0,  0, 0);

        // Round robin from reset.
        do_reset();
        cyc(1, 0, 0, 32'd8, 0,  1, 0, 0, 32'd16, 0,  1, 0);
        cyc(1, 0, 0, 32'd8, 0,  1, 0, 0, 32'd16, 0,  0, 1);
        cyc(1, 0, 0, 32'd8, 0,  1, 0, 0, 32'd16, 0,  1, 0);
        cyc(1, 0, 0, 32'd8, 0,  1, 0, 0, 32'd16, 0,  0, 1);

        // Bounded burst lock on port 1 against a waiting port 0.
        cyc(0, 0, 0, 0, 0,      1, 0, 1, 32'd20, 0,  0, 1);
        for (int i = 0; i < 3; i++)
            cyc(1, 0, 0, 32'd8, 0,  1, 0, 1, 32'd20, 0,  0, 1);
        cyc(1, 0, 0, 32'd8, 0,  1, 0, 1, 32'd20, 0,  1, 0);
        // Unopposed, the lock holds past the burst limit.
        for (int i = 0; i < 6; i++)
            cyc(0, 0, 0, 0, 0,  1, 0, (i < 5), 32'(24 + 4 * i), 0,  0, 1);

        // Misaligned write is suppressed and flagged.
        cyc(0, 0, 0, 0, 0,      1, 1, 0, 32'd6, 32'd99,  0, 1);
        chk("mem1_unchanged", mem[1], 32'd44);

        // Write then read of the same word.
        cyc(1, 1, 0, 32'd12, 32'd77,  1, 0, 0, 32'd12, 0,  1, 0);
        cyc(0, 0, 0, 0, 0,            1, 0, 0, 32'd12, 0,  0, 1);
        chk("mem3_written", mem[3], 32'd77);

        // Reset in the middle of a locked burst drops the pending return.
        cyc(0, 0, 0, 0, 0,      1, 0, 1, 32'd8, 0,  0, 1);
        cyc(0, 0, 0, 0, 0,      1, 0, 1, 32'd8, 0,  0, 1);
        #2;
        rst_n = 0;
        #1;
        chk("rst_mid_rvalid1", {31'd0, rvalid1}, 32'd0);
        chk("rst_mid_gnt1", {31'd0, gnt1}, 32'd0);
        @(negedge clk);
        set_idle();
        rst_n = 1;
        exp_q.delete();
        cyc(1, 0, 0, 32'd8, 0,  1, 0, 0, 32'd16, 0,  1, 0);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/data_memory_arbiter.md
Name: data_memory_arbiter

Overview:
- Shares the single-port data_memory between two requesters: port 0 (mips_cpu data side) and port 1 (debug/DMA master, e.g. a memory loader or dump engine).
- Round-robin arbitration with an optional bounded lock for bursts, a registered read-return path and misalignment checking.
- Sits between the requesters and data_memory (a, we, wd, rd); data_memory is unchanged (combinational read, write on rising clk).

Parameters:
- MAX_BURST, 4, maximum consecutive grants a locking owner may hold while the other port requests (>=1).
- CNT_W, 3, burst counter width; must hold MAX_BURST.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0 / req1  in  1  request valid, port 0 / 1.
- we0 / we1  in  1  1 = write, 0 = read.
- lock0 / lock1  in  1  request to keep ownership next cycle.
- addr0 / addr1  in  32  byte address.
- wd0 / wd1  in  32  write data.
- gnt0 / gnt1  out  1  combinational grant; transaction commits on this rising edge.
- rvalid0 / rvalid1  out  1  registered read-data valid, one cycle after a granted read.
- rdata0 / rdata1  out  32  registered read data.
- err0 / err1  out  1  registered one-cycle pulse: granted access was misaligned.
- mem_a  out  32  to data_memory.a.
- mem_we  out  1  to data_memory.we.
- mem_wd  out  32  to data_memory.wd.
- mem_rd  in  32  from data_memory.rd.

Behaviour:
- Reset (rst_n low, async): state=IDLE, last=1 (port 0 wins first tie), burst_cnt=0, rvalid*/err*=0, rdata*=0. gnt*=0 and mem_we=0 while rst_n low. An outstanding rvalid/err is dropped, not delivered.
- At most one grant per cycle; gnt0 & gnt1 never both 1. No grant without the matching req.
- State IDLE arbitration:
  - single requester is granted;
  - both requesting: grant the port != last;
  - on each grant, last <= granted port.
- Lock: if a granted port has its lock=1, next state = OWNx and burst_cnt <= 1.
- State OWNx:
  - if req_x and (burst_cnt < MAX_BURST or other port idle): grant x; burst_cnt increments, saturating at MAX_BURST;
  - stay in OWNx while lock_x=1; otherwise go to IDLE;
  - if req_x=0, or burst_cnt == MAX_BURST with the other port requesting: arbitrate as IDLE this cycle; state=IDLE, burst_cnt=0 (unless the new grantee locks).
- Mux: mem_a, mem_wd come from the granted port; all zero when no grant.
- Write enable: mem_we = gnt & we & (addr[1:0]==0).
- Granted read: rdataX <= mem_rd and rvalidX <= 1 at the edge; latency is 1 cycle. rvalid is a single-cycle pulse per read; back-to-back reads give consecutive pulses.
- Misaligned access (addr[1:0]!=0): still granted (consumes the slot). Write is suppressed; a read returns rvalid=1 with rdata=0. errX pulses 1 cycle after the grant.
- Write then read of the same address in consecutive grants: the read sees the new data.

Test Plan:
- mem[2]=55; req0 read addr 8 alone -> gnt0=1 same cycle; next cycle rvalid0=1, rdata0=55, gnt1=0 throughout.
- req0 & req1 reads held 4 cycles, no lock, from reset -> grants 0,1,0,1; each rvalid follows its grant by 1 cycle.
- MAX_BURST=4; req1+lock1 held, req0 held -> gnt1 for exactly 4 cycles, then gnt0; with req0=0, port 1 keeps grant beyond 4.
- req1 write addr 6 wd=99 -> gnt1=1, mem_we=0, err1 pulse next cycle, mem[1] unchanged.
- Same cycle: req0 write addr 12 wd=77 and req1 read addr 12 -> port 0 first, then port 1 granted; rdata1=77.
- rst_n low during a port-1 locked burst with a read outstanding -> rvalid1 clears immediately; after release, a simultaneous request is granted to port 0.
